// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake plus the shared full-adder link for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, cin, fa_sum, fa_cout,
`ifdef SERIAL_ADD_OVF_EN
      input  ovf,
`endif
      input  fa_a, fa_b, fa_cin, busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin, fa_sum, fa_cout,
`ifdef SERIAL_ADD_OVF_EN
      output ovf,
`endif
      output fa_a, fa_b, fa_cin, busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer around one shared full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow flag.
module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             w_last;
   logic             w_run;
`ifdef SERIAL_ADD_OVF_EN
   logic             r_ovf;
`endif

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_next = r_state;
      w_run  = 1'b0;
      unique case (r_state)
         S_IDLE: if (bus.start) w_next = S_RUN;
         S_RUN: begin
            w_run = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sa    <= '0;
         r_sb    <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_sa    <= bus.a;
                  r_sb    <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_sum   <= {bus.fa_sum, r_sum[WIDTH-1:1]};
               r_sa    <= r_sa >> 1;
               r_sb    <= r_sb >> 1;
               r_carry <= bus.fa_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cout <= bus.fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                  // carry into MSB vs carry out of MSB
                  r_ovf  <= r_carry ^ bus.fa_cout;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.fa_a   = w_run & r_sa[0];
   assign bus.fa_b   = w_run & r_sb[0];
   assign bus.fa_cin = w_run & r_carry;
   assign bus.busy   = w_run;
   assign bus.done   = (r_state == S_DONE);
   assign bus.sum    = r_sum;
   assign bus.cout   = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf    = r_ovf;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed vector bench for serial_add_ctrl (WIDTH=4) with a behavioural
// full adder on the shared link.
module tb_serial_add_ctrl;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
   assign bus.fa_cout = (bus.fa_a & bus.fa_b) |
                        (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, output int lat, output int bcnt);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = c;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.cin   = ~c;
      lat  = 0;
      bcnt = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
   endtask

   vec_t vt[10];
   int   lat;
   int   bcnt;
   int   dn;
   int   t_last;
   int   ps;
   logic [W-1:0] ebits;

   initial begin
      vt[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1};
      vt[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
      vt[2] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b0, 1'b1};
      vt[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
      vt[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vt[5] = '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1, 1'b0};
      vt[6] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
      vt[7] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
      vt[8] = '{4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};
      vt[9] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0, 1'b0};

      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd5;
      bus.cin   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_sum",  int'(bus.sum),  0);
      chk("rst_cout", int'(bus.cout), 0);
      chk("rst_fa",   int'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf",  int'(bus.ovf), 0);
`endif
      bus.start = 1'b0;
      rst       = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_add(vt[i].a, vt[i].b, vt[i].cin, lat, bcnt);
         chk($sformatf("v%0d_lat", i),  lat,  W + 1);
         chk($sformatf("v%0d_busy", i), bcnt, W);
         chk($sformatf("v%0d_sum", i),  int'(bus.sum),  int'(vt[i].sum));
         chk($sformatf("v%0d_cout", i), int'(bus.cout), int'(vt[i].cout));
`ifdef SERIAL_ADD_OVF_EN
         chk($sformatf("v%0d_ovf", i),  int'(bus.ovf),  int'(vt[i].ovf));
`endif
      end

      // last vector left sum=15; it must hold through the first RUN cycle
      @(negedge clk);
      chk("idle_hold", int'(bus.sum), 15);
      chk("idle_fa", int'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);
      bus.start = 1'b1;
      bus.a     = 4'd7;
      bus.b     = 4'd7;
      bus.cin   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 4'd0;
      bus.b     = 4'd0;
      bus.cin   = 1'b0;
      ebits = 4'b0111;
      for (int n = 0; n < W; n++) begin
         @(negedge clk);
         if (n == 0) chk("run0_hold", int'(bus.sum), 15);
         chk($sformatf("tr%0d_fa_a", n), int'(bus.fa_a), int'(ebits[n]));
         chk($sformatf("tr%0d_fa_b", n), int'(bus.fa_b), int'(ebits[n]));
         chk($sformatf("tr%0d_fa_cin", n), int'(bus.fa_cin), 1);
      end
      @(negedge clk);
      chk("tr_done", int'(bus.done), 1);
      chk("tr_sum", int'(bus.sum), 15);
      chk("tr_fa_done", int'({bus.fa_a, bus.fa_b, bus.fa_cin}), 0);

      // start re-asserted during RUN is ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd2;
      bus.b     = 4'd2;
      bus.cin   = 1'b0;
      dn = 0;
      ps = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.a = 4'd1;
            bus.b = 4'd1;
         end
         if (n == 4) bus.start = 1'b0;
         if (bus.done) begin
            dn++;
            ps = int'(bus.sum);
         end
      end
      chk("mid_start_dones", dn, 1);
      chk("mid_start_sum", ps, 4);

      // reset in the second RUN cycle aborts
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd9;
      bus.b     = 4'd9;
      bus.cin   = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_pre", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_sum",  int'(bus.sum),  0);
      chk("abort_cout", int'(bus.cout), 0);
      dn = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dn++;
      end
      chk("abort_quiet", dn, 0);
      run_add(4'd6, 4'd4, 1'b0, lat, bcnt);
      chk("post_abort_lat", lat, W + 1);
      chk("post_abort_sum", int'(bus.sum), 10);

      // start held high: one result every WIDTH+2 cycles
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd1;
      bus.b     = 4'd2;
      bus.cin   = 1'b0;
      dn     = 0;
      t_last = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.done) begin
            if (dn == 0) chk("held_first", n, W + 1);
            else chk($sformatf("held_gap%0d", dn), n - t_last, W + 2);
            chk($sformatf("held_sum%0d", dn), int'(bus.sum), 3);
            t_last = n;
            dn++;
         end
      end
      chk("held_pulses", dn, 6);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);

      // full 4-bit sweep
      for (int i = 0; i < 512; i++) begin
         logic [W-1:0] ta;
         logic [W-1:0] tb;
         logic         tc;
         ta = W'(i >> 5);
         tb = W'(i >> 1);
         tc = i[0];
         run_add(ta, tb, tc, lat, bcnt);
         chk($sformatf("sw_%0d_%0d_%0d", ta, tb, tc),
             int'({bus.cout, bus.sum}) + (lat == W + 1 ? 0 : 1000),
             int'(ta) + int'(tb) + int'(tc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that time-shares one external single-bit full_adder to add two WIDTH-bit operands, one bit per clock, LSB first.
It sits between the switch/operand inputs and a shared full_adder instance.
It owns operand shift registers, the carry flop, the bit counter and a start/busy/done handshake.
It replaces a ripple chain of WIDTH full adders with one adder plus sequencing.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry-in, captured on accepted start
fa_a  output  1  bit to shared full_adder input a
fa_b  output  1  bit to shared full_adder input b
fa_cin  output  1  carry to shared full_adder carry input
fa_sum  input  1  full_adder sum return (combinational from fa_a/fa_b/fa_cin)
fa_cout  input  1  full_adder carry return
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/cout are valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - State IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flop and bit counter all cleared.
  - fa_a=fa_b=fa_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_* outputs are driven 0.
  - On an edge with start=1: capture a into sa, b into sb, cin into carry; count<=0; go to RUN.
  - sum and cout keep their previous values until the first RUN edge.
- RUN (busy=1):
  - fa_a=sa[0], fa_b=sb[0], fa_cin=carry (combinational from registers).
  - Each edge: sum <= {fa_sum, sum[WIDTH-1:1]}; sa, sb shift right by 1; carry <= fa_cout; count <= count+1.
  - At the edge where count==WIDTH-1: cout <= fa_cout and go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - fa_* outputs are driven 0.
  - Returns unconditionally to IDLE.
- Latency:
  - Start accepted at edge k; RUN occupies edges k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after the start edge.
  - Throughput is one addition per WIDTH+2 cycles.
- Arithmetic: {cout,sum} == a + b + cin, unsigned, exact for all inputs.
- start handling:
  - start is level-sampled.
  - It is ignored in RUN and DONE; there is no queueing.
  - start held high continuously launches a new addition on each visit to IDLE.
- Operand stability: a, b and cin may change freely after the start edge; only the captured copies are used.
- Reset mid-operation: rst in RUN or DONE aborts immediately. All reset values apply on that edge, and done does not pulse.
- Simultaneous rst and start: rst wins; the block stays in IDLE with no capture.
- Counter width is clog2(WIDTH)+1 bits, so there is no wrap in RUN.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit) with a reset value of 0.
  - At the final RUN edge, ovf <= carry ^ fa_cout, i.e. carry into MSB XOR carry out of MSB (two's-complement overflow).
  - ovf is held with sum and cleared on reset.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=3, b=5, cin=0, start pulse: done exactly 5 cycles after the start edge, sum=8, cout=0, busy high for 4 cycles.
- a=15, b=1, cin=0: sum=0, cout=1. Then a=7, b=7, cin=1: sum=15, cout=0. Check fa_a/fa_b follow bits LSB-first (1,1,1,0 for a=7).
- start re-asserted with a=1, b=1 during RUN of a=2, b=2 addition: ignored; result sum=4, exactly one done pulse.
- rst asserted at the 2nd RUN cycle of a=9, b=9: next cycle busy=0, done=0, sum=0, cout=0, state IDLE. A following start with a=6, b=4 gives sum=10.
- start held high continuously: done pulses every 6 cycles. Exhaustive 4-bit sweep of a, b, cin (512 cases) matches a+b+cin.
- With SERIAL_ADD_OVF_EN: a=7, b=1 -> sum=8, ovf=1. a=8, b=8 -> sum=0, cout=1, ovf=1. a=3, b=2 -> ovf=0.
